// File: rtl/fabric_instr_loader_pkg.sv
// Shared types and width helpers for the fabric instruction loader.
// Timeout watchdog is enabled by defining FABRIC_INSTR_LOADER_TIMEOUT_EN.
package fabric_instr_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCall,
      StWait,
      StFin
   } loader_state_e;

   // Index width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned DefRows  = 2;
   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 4;
   localparam int unsigned DefHopsW = 4;
   localparam int unsigned DefRowW  = clog2_min1(DefRows);

   typedef struct packed {
      logic [DefRowW-1:0]  row;
      logic [DefHopsW-1:0] hops;
      logic [DefAddrW-1:0] addr;
      logic [DefDataW-1:0] data;
      logic                last;
   } instr_beat_t;

endpackage

// File: rtl/fabric_instr_loader_ret_watch.sv
// Post-call ret monitor: guard window, masked ret compare and optional WAIT timeout.
// Timeout counter present only when FABRIC_INSTR_LOADER_TIMEOUT_EN is defined.
module fabric_instr_loader_ret_watch
   import fabric_instr_loader_pkg::*;
#(
   parameter int unsigned ROWS           = 2,
   parameter int unsigned CALL_GUARD     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wait_i,
   input  logic [ROWS-1:0] mask_i,
   input  logic [ROWS-1:0] ret_i,
   output logic            ret_ok_o,
   output logic            timeout_o
);

   localparam int unsigned GuardW = clog2_min1(CALL_GUARD + 1);

   logic [GuardW-1:0] guard_q, guard_d;
   logic              guard_done;

   // Counter saturates at CALL_GUARD; ret is only trusted once it gets there.
   assign guard_done = (32'(guard_q) >= CALL_GUARD);

   always_comb begin
      guard_d = '0;
      if (wait_i) begin
         guard_d = guard_done ? guard_q : guard_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         guard_q <= '0;
      end else begin
         guard_q <= guard_d;
      end
   end

   assign ret_ok_o = wait_i && guard_done && ((ret_i & mask_i) == mask_i);

`ifdef FABRIC_INSTR_LOADER_TIMEOUT_EN
   localparam int unsigned TmoW = clog2_min1(TIMEOUT_CYCLES);

   logic [TmoW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = '0;
      if (wait_i) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   // Fires in the last permitted WAIT cycle so FIN lands exactly TIMEOUT_CYCLES after entry.
   assign timeout_o = wait_i && (32'(tmo_q) == TIMEOUT_CYCLES - 1);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_o          = 1'b0;
`endif

endmodule

// File: rtl/fabric_instr_loader.sv
// Host-to-fabric instruction loader: steers beats onto row buses, calls rows, awaits ret.
// Optional WAIT timeout via FABRIC_INSTR_LOADER_TIMEOUT_EN.
module fabric_instr_loader
   import fabric_instr_loader_pkg::*;
#(
   parameter int unsigned ROWS             = 2,
   parameter int unsigned INSTR_DATA_WIDTH = 32,
   parameter int unsigned INSTR_ADDR_WIDTH = 4,
   parameter int unsigned INSTR_HOPS_WIDTH = 4,
   parameter int unsigned CALL_GUARD       = 2,
   parameter int unsigned TIMEOUT_CYCLES   = 4096,
   localparam int unsigned RowW            = clog2_min1(ROWS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [ROWS-1:0]                        row_mask,
   input  logic                                   s_valid,
   output logic                                   s_ready,
   input  logic [RowW-1:0]                        s_row,
   input  logic [INSTR_HOPS_WIDTH-1:0]            s_hops,
   input  logic [INSTR_ADDR_WIDTH-1:0]            s_addr,
   input  logic [INSTR_DATA_WIDTH-1:0]            s_data,
   input  logic                                   s_last,
   output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]  instr_data_out,
   output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]  instr_addr_out,
   output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]  instr_hops_out,
   output logic [ROWS-1:0]                        instr_en_out,
   output logic [ROWS-1:0]                        call_out,
   input  logic [ROWS-1:0]                        ret_in,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   error
);

   loader_state_e state_q, state_d;

   logic [ROWS-1:0]                       mask_q, mask_d;
   logic [ROWS-1:0]                       en_q, en_d;
   logic [ROWS-1:0]                       call_q, call_d;
   logic                                  error_q, error_d;
   logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0] data_q, data_d;
   logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0] hops_q, hops_d;

   logic accept, row_ok, ret_ok, timeout;

   assign accept = (state_q == StLoad) && s_valid;
   assign row_ok = (32'(s_row) < ROWS);

   fabric_instr_loader_ret_watch #(
      .ROWS           (ROWS),
      .CALL_GUARD     (CALL_GUARD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_ret_watch (
      .clk_i     (clk),
      .rst_i     (rst),
      .wait_i    (state_q == StWait),
      .mask_i    (mask_q),
      .ret_i     (ret_in),
      .ret_ok_o  (ret_ok),
      .timeout_o (timeout)
   );

   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      busy    = (state_q != StIdle);
      done    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StLoad;
         end
         StLoad: begin
            s_ready = 1'b1;
            // An empty mask skips the call entirely.
            if (s_valid && s_last) state_d = (mask_q == '0) ? StFin : StCall;
         end
         StCall: state_d = StWait;
         StWait: begin
            if (ret_ok || timeout) state_d = StFin;
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mask_d  = mask_q;
      error_d = error_q;
      en_d    = '0;
      data_d  = data_q;
      addr_d  = addr_q;
      hops_d  = hops_q;
      // call_out lags the CALL state so it follows the final instr_en cycle.
      call_d  = (state_q == StCall) ? mask_q : '0;

      if (state_q == StIdle && start) begin
         mask_d  = row_mask;
         error_d = 1'b0;
      end

      if (accept) begin
         if (row_ok) begin
            en_d[s_row]   = 1'b1;
            data_d[s_row] = s_data;
            addr_d[s_row] = s_addr;
            hops_d[s_row] = s_hops;
         end else begin
            error_d = 1'b1;
         end
      end

      if (state_q == StWait && timeout && !ret_ok) error_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mask_q  <= '0;
         en_q    <= '0;
         call_q  <= '0;
         error_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         hops_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         en_q    <= en_d;
         call_q  <= call_d;
         error_q <= error_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         hops_q  <= hops_d;
      end
   end

   assign instr_en_out   = en_q;
   assign instr_data_out = data_q;
   assign instr_addr_out = addr_q;
   assign instr_hops_out = hops_q;
   assign call_out       = call_q;
   assign error          = error_q;

endmodule

// File: tb/tb_fabric_instr_loader.sv
// Directed bench for fabric_instr_loader; ROWS=3 so an out-of-range s_row of 3 is encodable.
// Timeout cases run only when FABRIC_INSTR_LOADER_TIMEOUT_EN is defined.
module tb_fabric_instr_loader;

   localparam int unsigned Rows  = 3;
   localparam int unsigned DataW = 32;
   localparam int unsigned AddrW = 4;
   localparam int unsigned HopsW = 4;
   localparam int unsigned Guard = 2;
   localparam int unsigned Tmo   = 16;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         start;
   logic [Rows-1:0]              row_mask;
   logic                         s_valid;
   logic                         s_ready;
   logic [1:0]                   s_row;
   logic [HopsW-1:0]             s_hops;
   logic [AddrW-1:0]             s_addr;
   logic [DataW-1:0]             s_data;
   logic                         s_last;
   logic [Rows-1:0][DataW-1:0]   instr_data_out;
   logic [Rows-1:0][AddrW-1:0]   instr_addr_out;
   logic [Rows-1:0][HopsW-1:0]   instr_hops_out;
   logic [Rows-1:0]              instr_en_out;
   logic [Rows-1:0]              call_out;
   logic [Rows-1:0]              ret_in;
   logic                         busy;
   logic                         done;
   logic                         error;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   fabric_instr_loader #(
      .ROWS             (Rows),
      .INSTR_DATA_WIDTH (DataW),
      .INSTR_ADDR_WIDTH (AddrW),
      .INSTR_HOPS_WIDTH (HopsW),
      .CALL_GUARD       (Guard),
      .TIMEOUT_CYCLES   (Tmo)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .row_mask       (row_mask),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_row          (s_row),
      .s_hops         (s_hops),
      .s_addr         (s_addr),
      .s_data         (s_data),
      .s_last         (s_last),
      .instr_data_out (instr_data_out),
      .instr_addr_out (instr_addr_out),
      .instr_hops_out (instr_hops_out),
      .instr_en_out   (instr_en_out),
      .call_out       (call_out),
      .ret_in         (ret_in),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [Rows-1:0] mask);
      start    = 1'b1;
      row_mask = mask;
      step();
      start    = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] row, input logic [HopsW-1:0] hops,
                            input logic [AddrW-1:0] addr, input logic [DataW-1:0] data,
                            input logic last);
      s_valid = 1'b1;
      s_row   = row;
      s_hops  = hops;
      s_addr  = addr;
      s_data  = data;
      s_last  = last;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      bit seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         step();
         if (done) seen = 1'b1;
      end
      check_eq(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      int n_done;
      rst = 1'b1; start = 1'b0; row_mask = '0; s_valid = 1'b0; s_row = '0;
      s_hops = '0; s_addr = '0; s_data = '0; s_last = 1'b0; ret_in = '0;
      step();
      step();

      // Reset state
      check_eq("rst_en", 64'(instr_en_out), 64'h0);
      check_eq("rst_call", 64'(call_out), 64'h0);
      check_eq("rst_ready", 64'(s_ready), 64'h0);
      check_eq("rst_busy", 64'(busy), 64'h0);
      check_eq("rst_done_err", 64'({done, error}), 64'h0);
      check_eq("rst_data0", 64'(instr_data_out[0]), 64'h0);

      // Reset while a beat is being accepted in LOAD
      rst = 1'b0;
      start_run(3'b011);
      check_eq("load_ready", 64'(s_ready), 64'h1);
      s_valid = 1'b1; s_row = 2'd0; s_data = 32'h0BAD_0BAD; s_last = 1'b0;
      rst = 1'b1;
      step();
      check_eq("midrst_en", 64'(instr_en_out), 64'h0);
      check_eq("midrst_call", 64'(call_out), 64'h0);
      check_eq("midrst_ready", 64'(s_ready), 64'h0);
      check_eq("midrst_busy", 64'(busy), 64'h0);
      rst = 1'b0; s_valid = 1'b0;
      step();
      check_eq("postrst_en_call", 64'({instr_en_out, call_out}), 64'h0);
      check_eq("postrst_data0", 64'(instr_data_out[0]), 64'h0);

      // Back-to-back program: en on rows 0,1,1 then call
      start_run(3'b011);
      check_eq("busy_load", 64'(busy), 64'h1);
      send_beat(2'd0, 4'h2, 4'h1, 32'h1111_1111, 1'b0);
      check_eq("b0_en", 64'(instr_en_out), 64'h1);
      check_eq("b0_data", 64'(instr_data_out[0]), 64'h1111_1111);
      check_eq("b0_addr_hops", 64'({instr_addr_out[0], instr_hops_out[0]}), 64'h12);
      send_beat(2'd1, 4'h3, 4'h4, 32'h2222_2222, 1'b0);
      check_eq("b1_en", 64'(instr_en_out), 64'h2);
      check_eq("b1_data", 64'(instr_data_out[1]), 64'h2222_2222);
      send_beat(2'd1, 4'h7, 4'h5, 32'hDEAD_BEEF, 1'b1);
      check_eq("b2_en", 64'(instr_en_out), 64'h2);
      check_eq("b2_data", 64'(instr_data_out[1]), 64'hDEAD_BEEF);
      check_eq("b2_addr_hops", 64'({instr_addr_out[1], instr_hops_out[1]}), 64'h57);
      check_eq("b2_hold_row0", 64'(instr_data_out[0]), 64'h1111_1111);
      check_eq("b2_ready_low", 64'(s_ready), 64'h0);
      check_eq("b2_no_call", 64'(call_out), 64'h0);
      ret_in = 3'b011;
      step();  // call cycle C
      check_eq("call_mask", 64'(call_out), 64'h3);
      check_eq("call_en_off", 64'(instr_en_out), 64'h0);
      check_eq("call_no_done", 64'(done), 64'h0);
      step();  // C+1
      check_eq("guard1_call_off", 64'(call_out), 64'h0);
      check_eq("guard1_done", 64'(done), 64'h0);
      step();  // C+2
      check_eq("guard2_done", 64'(done), 64'h0);
      step();  // C+3
      check_eq("fin_done", 64'(done), 64'h1);
      check_eq("fin_err", 64'(error), 64'h0);
      step();
      check_eq("idle_done", 64'(done), 64'h0);
      check_eq("idle_busy", 64'(busy), 64'h0);
      ret_in = '0;

      // Out-of-range row sets sticky error; partial ret does not complete
      start_run(3'b100);
      send_beat(2'd3, 4'h1, 4'h1, 32'hFFFF_0000, 1'b0);
      check_eq("badrow_en", 64'(instr_en_out), 64'h0);
      check_eq("badrow_err", 64'(error), 64'h1);
      send_beat(2'd2, 4'h6, 4'h9, 32'hA5A5_A5A5, 1'b1);
      check_eq("row2_en", 64'(instr_en_out), 64'h4);
      check_eq("row2_data", 64'(instr_data_out[2]), 64'hA5A5_A5A5);
      step();
      check_eq("row2_call", 64'(call_out), 64'h4);
      ret_in = 3'b011;
      for (int i = 0; i < 5; i++) step();
      check_eq("partial_ret_busy", 64'({busy, done}), 64'h2);
      ret_in = 3'b100;
      wait_done("badrow_done", 6);
      check_eq("badrow_err_at_done", 64'(error), 64'h1);
      ret_in = '0;
      step();

      // Next start clears error; start during WAIT is ignored
      start_run(3'b001);
      check_eq("err_cleared", 64'(error), 64'h0);
      send_beat(2'd0, 4'h0, 4'h0, 32'h0000_0042, 1'b1);
      check_eq("w_en", 64'(instr_en_out), 64'h1);
      step();
      check_eq("w_call", 64'(call_out), 64'h1);
      start = 1'b1; row_mask = 3'b110;
      step();
      start = 1'b0; row_mask = '0;
      step();
      ret_in = 3'b001;  // completes only if the latched mask is still 3'b001
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) n_done++;
      end
      check_eq("w_single_done", 64'(n_done), 64'd1);
      check_eq("w_idle", 64'({busy, error, call_out}), 64'h0);
      ret_in = '0;

      // Empty mask: FIN straight after LOAD with no call
      start_run(3'b000);
      send_beat(2'd1, 4'h1, 4'h2, 32'h3333_3333, 1'b1);
      check_eq("m0_en", 64'(instr_en_out), 64'h2);
      check_eq("m0_done", 64'(done), 64'h1);
      check_eq("m0_call", 64'(call_out), 64'h0);
      step();
      check_eq("m0_after", 64'({busy, done, call_out}), 64'h0);

`ifdef FABRIC_INSTR_LOADER_TIMEOUT_EN
      // No ret: done with error exactly Tmo cycles after WAIT entry
      start_run(3'b001);
      send_beat(2'd0, 4'h0, 4'h0, 32'h0, 1'b1);
      step();  // WAIT entry, call visible
      check_eq("tmo_call", 64'(call_out), 64'h1);
      n_done = 0;
      for (int i = 1; i < 16; i++) begin
         step();
         if (done) n_done++;
      end
      check_eq("tmo_early_done", 64'(n_done), 64'd0);
      step();
      check_eq("tmo_done", 64'(done), 64'h1);
      check_eq("tmo_err", 64'(error), 64'h1);
      step();

      // ret arriving in the expiry cycle wins
      start_run(3'b001);
      check_eq("tmo2_err_clr", 64'(error), 64'h0);
      send_beat(2'd0, 4'h0, 4'h0, 32'h0, 1'b1);
      step();
      for (int i = 1; i < 16; i++) step();
      ret_in = 3'b001;
      step();
      check_eq("tie_done", 64'(done), 64'h1);
      check_eq("tie_err", 64'(error), 64'h0);
      ret_in = '0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
